// File: rtl/powersave_ctrl_if.sv
// Handshake bundle between the powersave controller and its requester / clock generator.
// The master side drives the requests and observes the registered status outputs.
interface powersave_ctrl_if;
  logic       ps_req;
  logic       idle;
  logic       test_mode;
  logic       powersave;
  logic       clk_switching;
  logic       ps_ack;
  logic [7:0] ps_count;

  modport master (
    output ps_req,
    output idle,
    output test_mode,
    input  powersave,
    input  clk_switching,
    input  ps_ack,
    input  ps_count
  );

  modport slave (
    input  ps_req,
    input  idle,
    input  test_mode,
    output powersave,
    output clk_switching,
    output ps_ack,
    output ps_count
  );
endinterface

// File: rtl/powersave_ctrl.sv
// Powersave sequencer: waits for a run of idle cycles, then switches the clock generator
// into powersave behind a fixed settle window, and back out the same way.
module powersave_ctrl #(
  parameter int unsigned IDLE_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  powersave_ctrl_if.slave   bus
);

  localparam logic [2:0] RUN          = 3'd0;
  localparam logic [2:0] QUIESCE      = 3'd1;
  localparam logic [2:0] ENTER_SETTLE = 3'd2;
  localparam logic [2:0] PS           = 3'd3;
  localparam logic [2:0] EXIT_SETTLE  = 3'd4;

  localparam logic [7:0] IDLE_LAST   = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ps_count_q, ps_count_d;
  logic       powersave_q, powersave_d;
  logic       clk_switching_q, clk_switching_d;
  logic       ps_ack_q, ps_ack_d;

  // cnt is shared: consecutive idle cycles in QUIESCE, elapsed settle cycles in the settle states.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ps_count_d = ps_count_q;
    case (state_q)
      RUN: begin
        if (bus.ps_req && !bus.test_mode) begin
          state_d = QUIESCE;
          cnt_d   = 8'd0;
        end
      end
      QUIESCE: begin
        if (!bus.ps_req || bus.test_mode) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else if (bus.idle) begin
          if (cnt_q == IDLE_LAST) begin
            state_d = ENTER_SETTLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = 8'd0;
        end
      end
      ENTER_SETTLE: begin
        if (bus.test_mode) begin
          state_d = EXIT_SETTLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d    = PS;
          cnt_d      = 8'd0;
          ps_count_d = ps_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PS: begin
        if (!bus.ps_req || bus.test_mode) begin
          state_d = EXIT_SETTLE;
          cnt_d   = 8'd0;
        end
      end
      EXIT_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    powersave_d     = (state_d == ENTER_SETTLE) || (state_d == PS);
    clk_switching_d = (state_d == ENTER_SETTLE) || (state_d == EXIT_SETTLE);
    ps_ack_d        = (state_d == PS);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      cnt_q           <= 8'd0;
      ps_count_q      <= 8'd0;
      powersave_q     <= 1'b0;
      clk_switching_q <= 1'b0;
      ps_ack_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ps_count_q      <= ps_count_d;
      powersave_q     <= powersave_d;
      clk_switching_q <= clk_switching_d;
      ps_ack_q        <= ps_ack_d;
    end
  end

  assign bus.powersave     = powersave_q;
  assign bus.clk_switching = clk_switching_q;
  assign bus.ps_ack        = ps_ack_q;
  assign bus.ps_count      = ps_count_q;

endmodule

// File: tb/tb_powersave_ctrl.sv
// Directed and randomized checks of powersave_ctrl against a phase/countdown reference model.
module tb_powersave_ctrl;

  localparam int IDLE_CYCLES   = 8;
  localparam int SETTLE_CYCLES = 16;

  localparam int P_ACTIVE = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_GOING  = 2;
  localparam int P_ASLEEP = 3;
  localparam int P_WAKING = 4;

  logic sysClk;
  logic rst;
  int   total;
  int   bad;

  int   mPhase;
  int   mStreak;
  int   mLeft;
  int   mCount;

  powersave_ctrl_if bus ();

  powersave_ctrl #(
    .IDLE_CYCLES   (IDLE_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .sys_clk (sysClk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic idl, input logic tm);
    bus.ps_req    = req;
    bus.idle      = idl;
    bus.test_mode = tm;
  endtask

  task automatic modelReset();
    mPhase  = P_ACTIVE;
    mStreak = 0;
    mLeft   = 0;
    mCount  = 0;
  endtask

  // One clock edge of the behavioural model, fed by the same inputs the DUT sampled.
  task automatic modelStep();
    case (mPhase)
      P_ACTIVE: if (bus.ps_req && !bus.test_mode) begin mPhase = P_DRAIN; mStreak = 0; end
      P_DRAIN: begin
        if (!bus.ps_req || bus.test_mode) mPhase = P_ACTIVE;
        else if (bus.idle) begin
          mStreak++;
          if (mStreak == IDLE_CYCLES) begin mPhase = P_GOING; mLeft = SETTLE_CYCLES; end
        end else mStreak = 0;
      end
      P_GOING: begin
        if (bus.test_mode) begin mPhase = P_WAKING; mLeft = SETTLE_CYCLES; end
        else begin
          mLeft--;
          if (mLeft == 0) begin mPhase = P_ASLEEP; mCount = (mCount + 1) % 256; end
        end
      end
      P_ASLEEP: if (!bus.ps_req || bus.test_mode) begin mPhase = P_WAKING; mLeft = SETTLE_CYCLES; end
      default: begin
        mLeft--;
        if (mLeft == 0) mPhase = P_ACTIVE;
      end
    endcase
  endtask

  task automatic checkOutput(input string tag);
    logic expPs, expSw, expAck;
    expPs  = (mPhase == P_GOING) || (mPhase == P_ASLEEP);
    expSw  = (mPhase == P_GOING) || (mPhase == P_WAKING);
    expAck = (mPhase == P_ASLEEP);
    checkVal({tag, ".powersave"},     8'(bus.powersave),     8'(expPs));
    checkVal({tag, ".clk_switching"}, 8'(bus.clk_switching), 8'(expSw));
    checkVal({tag, ".ps_ack"},        8'(bus.ps_ack),        8'(expAck));
    checkVal({tag, ".ps_count"},      bus.ps_count,          8'(mCount));
  endtask

  task automatic stepCycle(input string tag);
    @(posedge sysClk);
    #1;
    modelStep();
    checkOutput(tag);
  endtask

  task automatic stepN(input string tag, input int n);
    for (int i = 0; i < n; i++) stepCycle(tag);
  endtask

  task automatic doReset();
    @(negedge sysClk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge sysClk);
    rst = 1'b0;
  endtask

  initial begin
    int riseAt, ackAt, dropAt, swCycles, ackCycles, savedCount;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    modelReset();
    #12;
    checkOutput("por");
    @(negedge sysClk);
    rst = 1'b0;
    stepN("runIdle", 3);

    $display("[TB] nominal entry");
    applyStimulus(1'b1, 1'b1, 1'b0);
    riseAt = -1;
    ackAt  = -1;
    for (int i = 1; i <= 30; i++) begin
      stepCycle("nominal");
      if (bus.powersave === 1'b1 && riseAt < 0) riseAt = i;
      if (bus.ps_ack === 1'b1 && ackAt < 0) ackAt = i;
    end
    checkVal("nominal.psLatency",  8'(riseAt - 1),      8'(IDLE_CYCLES));
    checkVal("nominal.ackLatency", 8'(ackAt - riseAt),  8'(SETTLE_CYCLES));
    checkVal("nominal.count",      bus.ps_count,        8'd1);

    $display("[TB] exit");
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle("exit");
    checkVal("exit.psLow",  8'(bus.powersave), 8'd0);
    checkVal("exit.ackLow", 8'(bus.ps_ack),    8'd0);
    swCycles = (bus.clk_switching === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      stepCycle("exit");
      if (bus.clk_switching === 1'b1) swCycles++;
    end
    checkVal("exit.switchCycles", 8'(swCycles), 8'(SETTLE_CYCLES));

    $display("[TB] idle interruption");
    savedCount = mCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle("idleDrop");
    stepN("idleDrop", 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle("idleDrop");
    dropAt = 5;
    applyStimulus(1'b1, 1'b1, 1'b0);
    riseAt = -1;
    for (int i = 6; i <= 20; i++) begin
      stepCycle("idleDrop");
      if (bus.powersave === 1'b1 && riseAt < 0) begin
        riseAt = i;
        checkVal("idleDrop.countAtEnter", bus.ps_count, 8'(savedCount));
      end
    end
    checkVal("idleDrop.delay", 8'(riseAt - dropAt), 8'(IDLE_CYCLES));
    stepN("idleDrop", 12);
    checkVal("idleDrop.countInPs", bus.ps_count, 8'(savedCount + 1));
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepN("idleDrop", 17);

    $display("[TB] test abort");
    savedCount = mCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepN("abort", IDLE_CYCLES + 1);
    stepN("abort", 2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle("abort");
    checkVal("abort.psLow", 8'(bus.powersave), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    swCycles = (bus.clk_switching === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      stepCycle("abort");
      if (bus.clk_switching === 1'b1) swCycles++;
    end
    checkVal("abort.switchCycles", 8'(swCycles),  8'(SETTLE_CYCLES));
    checkVal("abort.count",        bus.ps_count,  8'(savedCount));

    $display("[TB] withdrawal during settle");
    savedCount = mCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepN("withdraw", IDLE_CYCLES + 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    ackCycles = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle("withdraw");
      if (bus.ps_ack === 1'b1) ackCycles++;
    end
    checkVal("withdraw.ackPulse", 8'(ackCycles),  8'd1);
    checkVal("withdraw.count",    bus.ps_count,   8'(savedCount + 1));

    $display("[TB] reset in PS");
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepN("rstPs", IDLE_CYCLES + SETTLE_CYCLES + 1);
    checkVal("rstPs.inPs", 8'(bus.ps_ack), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rstPs.async");
    @(posedge sysClk);
    #1;
    checkOutput("rstPs.held");
    @(negedge sysClk);
    rst = 1'b0;
    stepN("rstPs.after", 3);

    $display("[TB] random");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 88) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0);
      stepCycle("random");
    end

    $display("[TB] count wrap");
    applyStimulus(1'b0, 1'b0, 1'b0);
    doReset();
    for (int e = 1; e <= 256; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      stepN("wrap", IDLE_CYCLES + SETTLE_CYCLES + 1);
      if (e == 255) checkVal("wrap.count255", bus.ps_count, 8'd255);
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepN("wrap", SETTLE_CYCLES + 1);
    end
    checkVal("wrap.count", bus.ps_count, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
